// File: rtl/cgra_ram_arb_pkg.sv
// Shared types and the round-robin pick helper for the CGRA RAM arbiter.
package cgra_ram_arb_pkg;

  localparam int MAX_REQ = 8;

  typedef logic [$clog2(MAX_REQ)-1:0] req_idx_t;

  // Scans from ptr upward and wraps. MAX_REQ is a power of two, so the
  // index wraps on its own; mask bits above the live requester count stay 0.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] mask,
                                                 input req_idx_t ptr);
    logic [MAX_REQ-1:0] gnt;
    logic               found;
    req_idx_t           idx;
    gnt   = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      idx = ptr + req_idx_t'(k);
      if (!found && mask[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/cgra_ram_arb_if.sv
// Requester-side bus of the CGRA RAM arbiter: request channel plus read response.
interface cgra_ram_arb_if #(
  parameter int NUM_REQ    = 4,
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 9
);
  // A request transfers on req_valid[i] && req_ready[i]. While valid && !ready the
  // requester holds we/addr/wdata and keeps valid high. Responses cannot be stalled.
  logic [NUM_REQ-1:0]                 req_valid;
  logic [NUM_REQ-1:0]                 req_ready;
  logic [NUM_REQ-1:0]                 req_we;
  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ-1:0][WIDTH-1:0]      req_wdata;
  logic [NUM_REQ-1:0]                 rsp_valid;
  logic [WIDTH-1:0]                   rsp_data;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/cgra_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, pointer moves past the winner when en_update is set.
module cgra_rr_arbiter
  import cgra_ram_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         en_update,
  output logic [N-1:0] gnt,
  output req_idx_t     gnt_idx
);

  req_idx_t           ptr_q, ptr_d;
  logic [MAX_REQ-1:0] mask;
  logic [MAX_REQ-1:0] pick;
  logic               unused_pick;

  always_comb begin
    mask         = '0;
    mask[N-1:0]  = req;
    pick         = rr_pick(mask, ptr_q);
    gnt          = pick[N-1:0];
    gnt_idx      = '0;
    for (int i = 0; i < N; i++) begin
      if (pick[i]) gnt_idx = req_idx_t'(i);
    end
    ptr_d = ptr_q;
    if (en_update && |gnt) begin
      ptr_d = (gnt_idx == req_idx_t'(N - 1)) ? '0 : gnt_idx + req_idx_t'(1);
    end
  end

  assign unused_pick = ^pick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/cgra_ram_arbiter.sv
// Shares one 1W/1R simple_ram between NUM_REQ requesters with independent write/read
// round-robin arbiters. Define CGRA_RAM_ARB_STATS_EN for per-requester stall counters.
module cgra_ram_arbiter
  import cgra_ram_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 512,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cgra_ram_arb_if.slave         bus,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [WIDTH-1:0]      ram_wr_data,
  output logic                  ram_rd_en,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [WIDTH-1:0]      ram_rd_data
`ifdef CGRA_RAM_ARB_STATS_EN
  ,
  input  logic                        stats_clr,
  output logic [NUM_REQ-1:0][15:0]    stall_cnt
`endif
);

  logic [NUM_REQ-1:0]    wr_req, rd_req, wr_gnt, rd_gnt;
  req_idx_t              wr_idx_unused, rd_idx;
  logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;
  logic [WIDTH-1:0]      wr_data;
  logic                  collision, rd_fire;
  logic                  rsp_pend_q, rsp_pend_d;
  req_idx_t              rsp_id_q, rsp_id_d;

  // Gating with rst_n keeps grants and RAM enables low for the whole reset window.
  always_comb begin
    wr_req = bus.req_valid &  bus.req_we & {NUM_REQ{rst_n}};
    rd_req = bus.req_valid & ~bus.req_we & {NUM_REQ{rst_n}};
  end

  cgra_rr_arbiter #(.N(NUM_REQ)) u_wr_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (wr_req),
    .en_update (1'b1),
    .gnt       (wr_gnt),
    .gnt_idx   (wr_idx_unused)
  );

  cgra_rr_arbiter #(.N(NUM_REQ)) u_rd_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (rd_req),
    .en_update (!collision),
    .gnt       (rd_gnt),
    .gnt_idx   (rd_idx)
  );

  always_comb begin
    wr_addr = '0;
    wr_data = '0;
    rd_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (wr_gnt[i]) begin
        wr_addr = bus.req_addr[i];
        wr_data = bus.req_wdata[i];
      end
      if (rd_gnt[i]) rd_addr = bus.req_addr[i];
    end
    // A same-address read waits one cycle so it observes the committed write.
    collision     = |wr_gnt && |rd_gnt && (wr_addr == rd_addr);
    rd_fire       = |rd_gnt && !collision;
    bus.req_ready = wr_gnt | (rd_gnt & {NUM_REQ{!collision}});
    ram_wr_en     = |wr_gnt;
    ram_wr_addr   = wr_addr;
    ram_wr_data   = wr_data;
    ram_rd_en     = rd_fire;
    ram_rd_addr   = rd_fire ? rd_addr : '0;
    rsp_pend_d    = rd_fire;
    rsp_id_d      = rd_fire ? rd_idx : rsp_id_q;
    bus.rsp_data  = rsp_pend_q ? ram_rd_data : '0;
    bus.rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.rsp_valid[i] = rsp_pend_q && (rsp_id_q == req_idx_t'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_pend_q <= 1'b0;
      rsp_id_q   <= '0;
    end else begin
      rsp_pend_q <= rsp_pend_d;
      rsp_id_q   <= rsp_id_d;
    end
  end

`ifdef CGRA_RAM_ARB_STATS_EN
  logic [NUM_REQ-1:0][15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      stall_cnt_d[i] = stall_cnt_q[i];
      if (stats_clr) begin
        stall_cnt_d[i] = '0;
      end else if (bus.req_valid[i] && !bus.req_ready[i] && (stall_cnt_q[i] != 16'hFFFF)) begin
        stall_cnt_d[i] = stall_cnt_q[i] + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_cgra_ram_arbiter.sv
// Bench for cgra_ram_arbiter: directed scenarios plus randomized traffic against a
// transaction-level reference model; includes a behavioural simple_ram.
module tb_cgra_ram_arbiter;

  localparam int N     = 4;
  localparam int W     = 32;
  localparam int DEPTH = 512;
  localparam int AW    = 9;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cgra_ram_arb_if #(.NUM_REQ(N), .WIDTH(W), .ADDR_WIDTH(AW)) bus ();

  logic          ram_wr_en, ram_rd_en;
  logic [AW-1:0] ram_wr_addr, ram_rd_addr;
  logic [W-1:0]  ram_wr_data, ram_rd_data;
`ifdef CGRA_RAM_ARB_STATS_EN
  logic               stats_clr;
  logic [N-1:0][15:0] stall_cnt;
`endif

  cgra_ram_arbiter #(.NUM_REQ(N), .WIDTH(W), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .ram_wr_en   (ram_wr_en),
    .ram_wr_addr (ram_wr_addr),
    .ram_wr_data (ram_wr_data),
    .ram_rd_en   (ram_rd_en),
    .ram_rd_addr (ram_rd_addr),
    .ram_rd_data (ram_rd_data)
`ifdef CGRA_RAM_ARB_STATS_EN
    ,
    .stats_clr   (stats_clr),
    .stall_cnt   (stall_cnt)
`endif
  );

  // Behavioural simple_ram: registered read, cleared while in reset.
  logic [W-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      ram_rd_data <= '0;
    end else begin
      if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
      if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
    end
  end

  // ---------------- reference model state ----------------
  int           n_vec = 0;
  int           n_err = 0;
  int           wptr_m, rptr_m;
  logic [W-1:0] ref_mem [DEPTH];
  logic [W-1:0] exp_q[$];
  int           id_q[$];
  int           rsp_cnt [N];
  logic [N-1:0] last_ready;

  logic [N-1:0]  drv_valid, drv_we;
  logic [AW-1:0] drv_addr  [N];
  logic [W-1:0]  drv_wdata [N];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    wptr_m = 0;
    rptr_m = 0;
    exp_q.delete();
    id_q.delete();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    last_ready = '0;
  endtask

  task automatic idle_drv();
    drv_valid = '0;
    drv_we    = '0;
    for (int i = 0; i < N; i++) begin
      drv_addr[i]  = '0;
      drv_wdata[i] = '0;
    end
  endtask

  // ---------------- driver + model step ----------------
  task automatic step();
    int           wg, rg, idx;
    logic [N-1:0] er, erv;
    logic [W-1:0] erd;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i] = drv_valid[i];
      bus.req_we[i]    = drv_we[i];
      bus.req_addr[i]  = drv_addr[i];
      bus.req_wdata[i] = drv_wdata[i];
    end
    #1;
    erv = '0;
    erd = '0;
    if (exp_q.size() > 0) begin
      erd = exp_q.pop_front();
      erv[id_q.pop_front()] = 1'b1;
    end
    check_eq("rsp_valid", 64'(bus.rsp_valid), 64'(erv));
    check_eq("rsp_data", 64'(bus.rsp_data), 64'(erd));
    for (int i = 0; i < N; i++) if (bus.rsp_valid[i]) rsp_cnt[i]++;

    wg = -1;
    rg = -1;
    for (int k = 0; k < N; k++) begin
      idx = (wptr_m + k) % N;
      if (wg < 0 && drv_valid[idx] && drv_we[idx]) wg = idx;
      idx = (rptr_m + k) % N;
      if (rg < 0 && drv_valid[idx] && !drv_we[idx]) rg = idx;
    end
    if (wg >= 0 && rg >= 0 && drv_addr[wg] == drv_addr[rg]) rg = -1;
    er = '0;
    if (wg >= 0) er[wg] = 1'b1;
    if (rg >= 0) er[rg] = 1'b1;

    check_eq("req_ready", 64'(bus.req_ready), 64'(er));
    check_eq("ram_wr_en", 64'(ram_wr_en), 64'(wg >= 0));
    check_eq("ram_wr_addr", 64'(ram_wr_addr), (wg >= 0) ? 64'(drv_addr[wg]) : 64'd0);
    check_eq("ram_wr_data", 64'(ram_wr_data), (wg >= 0) ? 64'(drv_wdata[wg]) : 64'd0);
    check_eq("ram_rd_en", 64'(ram_rd_en), 64'(rg >= 0));
    check_eq("ram_rd_addr", 64'(ram_rd_addr), (rg >= 0) ? 64'(drv_addr[rg]) : 64'd0);

    if (rg >= 0) begin
      exp_q.push_back(ref_mem[drv_addr[rg]]);
      id_q.push_back(rg);
      rptr_m = (rg + 1) % N;
    end
    if (wg >= 0) begin
      ref_mem[drv_addr[wg]] = drv_wdata[wg];
      wptr_m = (wg + 1) % N;
    end
    last_ready = er;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_drv();
    bus.req_valid = '1;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    model_reset();
    @(posedge clk);
    #1;
    check_eq("rst_ready", 64'(bus.req_ready), 64'd0);
    check_eq("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check_eq("rst_rsp_data", 64'(bus.rsp_data), 64'd0);
    check_eq("rst_wr_en", 64'(ram_wr_en), 64'd0);
    check_eq("rst_rd_en", 64'(ram_rd_en), 64'd0);
    bus.req_valid = '0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
`ifdef CGRA_RAM_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    idle_drv();
    do_reset();

    // single write then read
    drv_valid = 4'b0001; drv_we = 4'b0001; drv_addr[0] = 9'd5; drv_wdata[0] = 32'hDEADBEEF;
    step();
    drv_we = 4'b0000;
    step();
    idle_drv();
    step();
    check_eq("wr_rd_valid", 64'(bus.rsp_valid), 64'h1);
    check_eq("wr_rd_data", 64'(bus.rsp_data), 64'hDEADBEEF);

    // concurrent write and read to different addresses
    drv_valid = 4'b0001; drv_we = 4'b0001; drv_addr[0] = 9'd20; drv_wdata[0] = 32'hA5A5A5A5;
    step();
    idle_drv();
    drv_valid = 4'b0110; drv_we = 4'b0010;
    drv_addr[1] = 9'd10; drv_wdata[1] = 32'h11111111; drv_addr[2] = 9'd20;
    step();
    check_eq("conc_ready", 64'(bus.req_ready), 64'h6);
    idle_drv();
    step();
    check_eq("conc_rsp_valid", 64'(bus.rsp_valid), 64'h4);
    check_eq("conc_rsp_data", 64'(bus.rsp_data), 64'hA5A5A5A5);

    // same-address collision
    drv_valid = 4'b1001; drv_we = 4'b0001;
    drv_addr[0] = 9'd7; drv_wdata[0] = 32'h1234; drv_addr[3] = 9'd7;
    step();
    check_eq("coll_ready0", 64'(bus.req_ready), 64'h1);
    drv_valid = 4'b1000; drv_we = 4'b0000;
    step();
    check_eq("coll_ready1", 64'(bus.req_ready), 64'h8);
    idle_drv();
    step();
    check_eq("coll_rsp_valid", 64'(bus.rsp_valid), 64'h8);
    check_eq("coll_rsp_data", 64'(bus.rsp_data), 64'h1234);

    // reset while a read is in flight
    drv_valid = 4'b0010; drv_we = 4'b0000; drv_addr[1] = 9'd5;
    step();
    rst_n = 1'b0;
    idle_drv();
    bus.req_valid = '0;
    model_reset();
    @(posedge clk);
    #1;
    check_eq("rst_inflight_valid", 64'(bus.rsp_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drv_valid = 4'b1111; drv_we = 4'b0000;
    step();
    check_eq("rst_first_grant", 64'(bus.req_ready), 64'h1);
    idle_drv();
    step();

    // round-robin fairness after a clean reset
    do_reset();
    for (int i = 0; i < N; i++) rsp_cnt[i] = 0;
    drv_valid = 4'b1111; drv_we = 4'b0000;
    for (int i = 0; i < N; i++) drv_addr[i] = AW'(i);
    for (int c = 0; c < 8; c++) begin
      step();
      check_eq("rr_order", 64'(bus.req_ready), 64'(1 << (c % 4)));
    end
    idle_drv();
    step();
    for (int i = 0; i < N; i++) check_eq("rr_rsp_count", 64'(rsp_cnt[i]), 64'd2);

`ifdef CGRA_RAM_ARB_STATS_EN
    stats_clr = 1'b1;
    step();
    stats_clr = 1'b0;
    drv_valid = 4'b0111; drv_we = 4'b0000;
    for (int c = 0; c < 9; c++) step();
    idle_drv();
    step();
    for (int i = 0; i < 3; i++) check_eq("stall_cnt", 64'(stall_cnt[i]), 64'd6);
    check_eq("stall_cnt_idle", 64'(stall_cnt[3]), 64'd0);
    stats_clr = 1'b1;
    step();
    stats_clr = 1'b0;
    step();
    for (int i = 0; i < N; i++) check_eq("stall_clr", 64'(stall_cnt[i]), 64'd0);
`endif

    // randomized traffic; stalled requesters keep their request unchanged
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!(drv_valid[i] && !last_ready[i])) begin
          drv_valid[i] = ($urandom_range(0, 3) != 0);
          drv_we[i]    = 1'($urandom_range(0, 1));
          drv_addr[i]  = AW'($urandom_range(0, 7));
          drv_wdata[i] = $urandom;
        end
      end
      step();
    end
    idle_drv();
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cgra_ram_arbiter.md
Name: cgra_ram_arbiter

Overview:
- Shares one simple_ram instance (1 write port, 1 read port, 1-cycle registered read) between NUM_REQ requesters inside the CGRA subsystem, e.g. PE tiles plus the config/DMA loader.
- Runs two independent round-robin arbiters:
  - Write arbiter: grants one write per cycle.
  - Read arbiter: grants one read per cycle.
- Drives the RAM ports directly and routes each read response back to the requester that issued it.
- Resolves same-address read/write collisions deterministically.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 32, data width; matches the RAM.
- DEPTH, 512, RAM depth in words.
- ADDR_WIDTH, $clog2(DEPTH), word address width.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  [NUM_REQ-1:0]  request valid, one bit per requester.
- req_ready  out  [NUM_REQ-1:0]  request accepted this cycle.
- req_we  in  [NUM_REQ-1:0]  1 = write, 0 = read.
- req_addr  in  [NUM_REQ-1:0][ADDR_WIDTH-1:0]  word address.
- req_wdata  in  [NUM_REQ-1:0][WIDTH-1:0]  write data.
- rsp_valid  out  [NUM_REQ-1:0]  one-hot read-data-valid.
- rsp_data  out  WIDTH  read data, shared by all requesters.
- ram_wr_en  out  1  to RAM wr_en.
- ram_wr_addr  out  ADDR_WIDTH  to RAM wr_addr.
- ram_wr_data  out  WIDTH  to RAM wr_data.
- ram_rd_en  out  1  to RAM rd_en.
- ram_rd_addr  out  ADDR_WIDTH  to RAM rd_addr.
- ram_rd_data  in  WIDTH  from RAM rd_data.

Behaviour:
- Handshake:
  - A transfer occurs when req_valid[i] && req_ready[i].
  - req_ready is combinational from the current grant.
  - Requesters hold we/addr/wdata stable while valid && !ready; valid must not drop before acceptance.
- Write path:
  - Write candidates are requesters with valid && we.
  - Round-robin selects at most one. Priority starts at wptr; lowest index wins after rotation.
  - Granted write drives ram_wr_en=1, ram_wr_addr, ram_wr_data in the same cycle (combinational).
  - The RAM commits the write at the next edge.
- Read path:
  - Read candidates are requesters with valid && !we.
  - Separate round-robin pointer rptr.
  - Granted read drives ram_rd_en=1 and ram_rd_addr combinationally.
  - A registered rsp_id/rsp_pend captures the grant.
  - Next cycle: rsp_valid[rsp_id]=1 and rsp_data=ram_rd_data. Read latency is exactly 1 cycle after acceptance.
  - There is no response backpressure.
- Pointer update:
  - On a grant to index g, the pointer becomes (g+1) mod NUM_REQ.
  - With no grant, the pointer holds.
  - Pointers reset to 0.
- Collision:
  - Applies when the granted write and the granted read target the same address in the same cycle.
  - The read grant is suppressed: ready=0 for that reader, rptr is not updated, ram_rd_en=0.
  - The read issues the following cycle and returns the newly written data. The write is never stalled.
- Idle: with no valid requests, all ram_* enables are 0 and req_ready is all 0. Addr/data outputs are don't-care, but are driven to 0.
- Reset (async assert, sync deassert handled upstream):
  - req_ready=0, rsp_valid=0, rsp_data=0, ram_wr_en=0, ram_rd_en=0.
  - Pointers reset to 0; the pending response is squashed.
  - An in-flight read at reset produces no rsp_valid.
- Invariant: the only sequential state is wptr, rptr, rsp_pend, rsp_id, and optional counters.

Optional Feature:
- Macro: CGRA_RAM_ARB_STATS_EN.
- Defined:
  - Adds output stall_cnt [NUM_REQ-1:0][15:0].
  - Per-requester saturating count of cycles with valid && !ready.
  - Resets to 0; holds at 16'hFFFF.
  - Adds input stats_clr (1 bit), which synchronously zeros all counters; clr wins over increment.
- Not defined: neither port exists and no counter logic is generated.

Decomposition:
- Package cgra_ram_arb_pkg:
  - Localparam MAX_REQ=8.
  - Typedef req_idx_t (logic [$clog2(MAX_REQ)-1:0]).
  - Function rr_pick(mask, ptr) returning a one-hot grant.
- Sub-module cgra_rr_arbiter (params N; ports clk, rst_n, req, en_update, gnt one-hot, gnt_idx).
  - Instantiated twice, for write and read.
  - en_update lets the top suppress the read pointer update on a collision.
- The RAM itself is instantiated outside this block.

Test Plan:
- Single write then read: req0 writes addr 5 = 32'hDEADBEEF; next cycle req0 reads addr 5 -> rsp_valid=4'b0001 one cycle after acceptance, rsp_data=32'hDEADBEEF.
- Round-robin fairness: all 4 requesters hold read requests for 8 cycles -> grant order 0,1,2,3,0,1,2,3; each sees exactly 2 rsp_valid pulses.
- Concurrent read+write to different addresses: req1 writes addr 10, req2 reads addr 20 in the same cycle -> both ready=1 in the same cycle; req2 gets old addr-20 data.
- Collision: req0 writes addr 7 = 32'h1234 while req3 reads addr 7 -> req3 ready=0 this cycle, ready=1 next cycle; rsp_data=32'h1234 one cycle later.
- Reset mid-read: assert rst_n=0 in the cycle after a read grant -> rsp_valid stays 0; after release, first grant goes to requester 0.
- Stats (CGRA_RAM_ARB_STATS_EN): 3 requesters read continuously for 9 cycles -> each stall_cnt=6; pulse stats_clr -> all 0.
